// File: rtl/clm_encoder_if.sv
// Encoder bus: generator matrix, data/randomness offer, codeword handshake and delivery count.
// Bit 0 is the leftmost bit of every vector.
interface clm_encoder_if #(parameter int d = 4);
    logic [0:d-1][0:7] B;
    logic              in_valid;
    logic [0:7]        in_data;
    logic              rnd_valid;
    logic [0:d-1]      rnd;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [0:7+d]      out;
    logic [15:0]       enc_count;

    modport master (
        output B, in_valid, in_data, rnd_valid, rnd, out_ready,
        input  in_ready, out_valid, out, enc_count
    );

    modport slave (
        input  B, in_valid, in_data, rnd_valid, rnd, out_ready,
        output in_ready, out_valid, out, enc_count
    );
endinterface

// File: rtl/clm_encoder.sv
// Two-stage masked byte encoder: out = {in_data ^ (B^T * rnd), rnd}.
// Stage 1 holds the raw byte and mask, stage 2 holds the finished codeword.

module clm_enc_bit #(parameter int d = 4) (
    input  logic         din,
    input  logic [0:d-1] col,
    input  logic [0:d-1] rnd,
    output logic         dout
);
    assign dout = din ^ (^(col & rnd));
endmodule

module clm_encoder #(parameter int d = 4) (
    input  logic          clk,
    input  logic          rst,
    clm_encoder_if.slave  bus
);
    typedef struct packed {
        logic [0:7]   data;
        logic [0:d-1] rnd;
    } s1_t;

    s1_t          s1;
    logic         s1_v;
    logic         advance;
    logic         accept;
    logic [0:7+d] cw;

    // Stage 1 moves on when stage 2 is empty or being drained this cycle.
    assign advance      = s1_v && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !s1_v || advance;
    assign accept       = bus.in_valid && bus.rnd_valid && bus.in_ready;

    // B is sampled here, so a word picks up the matrix present when it enters stage 2.
    for (genvar i = 0; i < 8; i++) begin : g_bit
        logic [0:d-1] col;
        for (genvar j = 0; j < d; j++) begin : g_col
            assign col[j] = bus.B[j][i];
        end
        clm_enc_bit #(.d(d)) u_bit (
            .din  (s1.data[i]),
            .col  (col),
            .rnd  (s1.rnd),
            .dout (cw[i])
        );
    end
    assign cw[8:7+d] = s1.rnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1   <= '0;
        end else if (accept) begin
            s1_v    <= 1'b1;
            s1.data <= bus.in_data;
            s1.rnd  <= bus.rnd;
        end else if (advance) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.enc_count <= '0;
        end else begin
            if (advance) begin
                bus.out       <= cw;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (bus.out_valid && bus.out_ready)
                bus.enc_count <= bus.enc_count + 16'd1;
        end
    end
endmodule
